// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder slice.
// Format codes, forced J opcode, entry bundle and immediate-fit helper.
package inst_encoder_pkg;

   localparam int INSTW = 32;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OPCODE_J = 7'b1101111;

   typedef struct packed {
      logic [2:0]       fmt;
      logic [6:0]       opcode;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [INSTW-1:0] imm;
   } enc_req_t;

   // True when v is representable as an n-bit two's complement value.
   function automatic logic fits(input logic [31:0] v, input int n);
      logic [31:0] s;
      s = $signed(v) >>> (n - 1);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational RV32I packer: entry fields + semantic immediate -> word.
// Ports: req (entry bundle) in; word (encoded), range_ok (accept) out.
// IMM_RANGE_CHECK_EN: also rejects out-of-range immediates.
module imm_pack
   import inst_encoder_pkg::*;
(
   input  enc_req_t          req,
   output logic [INSTW-1:0]  word,
   output logic              range_ok
);

   logic legal;

   always_comb begin
      word  = '0;
      legal = 1'b1;
      unique case (req.fmt)
         FMT_R: word = {req.funct7, req.rs2, req.rs1,
                        req.funct3, req.rd, req.opcode};
         FMT_I: word = {req.imm[11:0], req.rs1,
                        req.funct3, req.rd, req.opcode};
         FMT_S: word = {req.imm[11:5], req.rs2, req.rs1,
                        req.funct3, req.imm[4:0], req.opcode};
         // B immediate arrives in halfword units.
         FMT_B: word = {req.imm[11], req.imm[9:4], req.rs2,
                        req.rs1, req.funct3, req.imm[3:0],
                        req.imm[10], req.opcode};
         FMT_U: word = {req.imm[31:12], req.rd, req.opcode};
         FMT_J: word = {req.imm[20], req.imm[10:1], req.imm[11],
                        req.imm[19:12], req.rd, OPCODE_J};
         default: legal = 1'b0;
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   logic fit;

   always_comb begin
      fit = 1'b1;
      unique case (req.fmt)
         FMT_I, FMT_S, FMT_B: fit = fits(req.imm, 12);
         FMT_U:               fit = (req.imm[11:0] == 12'd0);
         FMT_J:               fit = fits(req.imm, 21) && !req.imm[0];
         default:             fit = 1'b1;
      endcase
   end

   assign range_ok = legal && fit;
`else
   assign range_ok = legal;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Loader-side encoder: streams packed RV32I words into IMEM.
// Ports: clk, rst (async high), start/base_addr, in_* entry handshake,
//  imem_we/addr/wdata write port, busy, done, err, err_addr, count.
// IMM_RANGE_CHECK_EN: reject out-of-range immediates (see imm_pack).
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int AW    = 10,
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    base_addr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   input  logic             in_last,
   output logic             imem_we,
   output logic [AW-1:0]    imem_addr,
   output logic [31:0]      imem_wdata,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [AW-1:0]    err_addr,
   output logic [AW:0]      count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [AW:0] LIM  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

   logic [1:0]    state;
   logic          fin;
   logic [AW-1:0] nxt;
   enc_req_t      req;
   logic [31:0]   word;
   logic          ok;
   logic          acc;

   assign req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd,
                  rs1: in_rs1, rs2: in_rs2, funct3: in_funct3,
                  funct7: in_funct7, imm: in_imm};

   imm_pack u_pack (
      .req      (req),
      .word     (word),
      .range_ok (ok)
   );

   // fin: end of session decided, closing write still in flight.
   assign in_ready = (state == S_RUN) && !fin;
   assign busy     = (state == S_RUN);
   assign acc      = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         fin        <= 1'b0;
         nxt        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_addr   <= '0;
         count      <= '0;
      end else begin
         imem_we <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_RUN;
                  nxt      <= base_addr;
                  count    <= '0;
                  err      <= 1'b0;
                  err_addr <= '0;
                  done     <= 1'b0;
                  fin      <= ({1'b0, base_addr} >= LIM);
               end
            end
            S_RUN: begin
               if (fin) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  fin   <= 1'b0;
               end else if (acc) begin
                  if (ok) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= nxt;
                     imem_wdata <= word;
                     nxt        <= nxt + 1'b1;
                     count      <= count + 1'b1;
                     if ({1'b0, nxt} == LAST)
                        fin <= 1'b1;
                  end else begin
                     err <= 1'b1;
                     if (!err)
                        err_addr <= nxt;
                  end
                  if (in_last)
                     fin <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomised round-trip bench for inst_encoder.
// Emitted words are decoded and compared against the entries sent.
module tb_inst_encoder;

   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_fmt;
   logic [6:0]    in_opcode;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [2:0]    in_funct3;
   logic [6:0]    in_funct7;
   logic [31:0]   in_imm;
   logic          in_last;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy, done, err;
   logic [AW-1:0] err_addr;
   logic [AW:0]   count;

   inst_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
      .done(done), .err(err), .err_addr(err_addr), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          f;
      logic [6:0]  opc;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      int          addr;
   } ent_t;

   typedef struct {
      int          addr;
      logic [31:0] w;
      longint      t;
   } wr_t;

   ent_t   exq[$];
   wr_t    wq[$];
   int     total = 0;
   int     bad = 0;
   longint cyc = 0;
   int     maddr, merr_addr, mcnt;
   bit     merr;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (imem_we) wq.push_back('{int'(imem_addr), imem_wdata, cyc});

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Entry acceptance rule: which entries may be written.
   function automatic bit m_ok(int f, logic [31:0] v);
      longint s;
      s = longint'($signed(v));
      if (f > 5) return 0;
`ifdef IMM_RANGE_CHECK_EN
      if (f >= 1 && f <= 3) return s >= -2048 && s <= 2047;
      if (f == 4) return (longint'(v) % 4096) == 0;
      if (f == 5)
         return s >= -(64'sd1 << 20) && s <= (64'sd1 << 20) - 2
                && (s % 2) == 0;
`endif
      return 1;
   endfunction

   // Immediate a decoder should recover, after silent truncation.
   function automatic logic [31:0] exp_imm(int f, logic [31:0] v);
      longint s, u, t;
      s = longint'($signed(v));
      u = longint'(v);
      t = 0;
      case (f)
         1, 2, 3: begin
            t = s % 4096;
            if (t < 0) t += 4096;
            if (t >= 2048) t -= 4096;
         end
         4: t = u - (u % 4096);
         5: begin
            t = s % (64'sd1 << 21);
            if (t < 0) t += (64'sd1 << 21);
            if (t >= (64'sd1 << 20)) t -= (64'sd1 << 21);
            if ((t % 2) != 0) t -= 1;
         end
         default: t = 0;
      endcase
      return t[31:0];
   endfunction

   // Standard RV32I immediate decoder (B kept in halfword units).
   function automatic logic [31:0] dec(int f, logic [31:0] w);
      logic [11:0] a;
      logic [20:0] j;
      case (f)
         1: begin a = w[31:20]; return 32'($signed(a)); end
         2: begin a = {w[31:25], w[11:7]}; return 32'($signed(a)); end
         3: begin
            a = {w[31], w[7], w[30:25], w[11:8]};
            return 32'($signed(a));
         end
         4: return {w[31:12], 12'd0};
         5: begin
            j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
            return 32'($signed(j));
         end
         default: return 32'd0;
      endcase
   endfunction

   // Non-immediate fields present in a format; absent ones read as 0.
   function automatic logic [31:0] flds(int f, logic [6:0] f7,
      logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3,
      logic [4:0] rd, logic [6:0] opc);
      bit has_f7, has_rs2, has_rs1, has_f3, has_rd;
      has_f7  = (f == 0);
      has_rs2 = (f == 0 || f == 2 || f == 3);
      has_rs1 = (f <= 3);
      has_f3  = (f <= 3);
      has_rd  = (f == 0 || f == 1 || f == 4 || f == 5);
      return {has_f7 ? f7 : 7'd0, has_rs2 ? rs2 : 5'd0,
              has_rs1 ? rs1 : 5'd0, has_f3 ? f3 : 3'd0,
              has_rd ? rd : 5'd0, opc};
   endfunction

   function automatic ent_t rnd(int f);
      ent_t e;
      e.f    = f;
      e.opc  = 7'($urandom);
      e.rd   = 5'($urandom);
      e.rs1  = 5'($urandom);
      e.rs2  = 5'($urandom);
      e.f3   = 3'($urandom);
      e.f7   = 7'($urandom);
      e.addr = 0;
      case (f)
         1, 2, 3: e.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
         4:       e.imm = $urandom & 32'hFFFFF000;
         5: e.imm = (32'($urandom_range(0, (1 << 20) - 1))
                     - 32'h80000) << 1;
         default: e.imm = $urandom;
      endcase
      return e;
   endfunction

   function automatic ent_t mk(int f, logic [6:0] opc, logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
      logic [31:0] imm);
      ent_t e;
      e = '{f: f, opc: opc, rd: rd, rs1: rs1, rs2: rs2, f3: f3,
            f7: 7'd0, imm: imm, addr: 0};
      return e;
   endfunction

   task automatic begin_sess(int base);
      start     = 1'b1;
      base_addr = AW'(base);
      @(negedge clk);
      start     = 1'b0;
      maddr     = base;
      merr      = 0;
      merr_addr = 0;
      mcnt      = 0;
   endtask

   task automatic send(ent_t e, bit last);
      int n;
      in_fmt    = 3'(e.f);
      in_opcode = e.opc;
      in_rd     = e.rd;
      in_rs1    = e.rs1;
      in_rs2    = e.rs2;
      in_funct3 = e.f3;
      in_funct7 = e.f7;
      in_imm    = e.imm;
      in_last   = last;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (m_ok(e.f, e.imm)) begin
         e.f = (e.f == 5) ? 5 : e.f;
         if (e.f == 5) e.opc = 7'b1101111;
         e.addr = maddr;
         exq.push_back(e);
         maddr++;
         mcnt++;
      end else if (!merr) begin
         merr      = 1;
         merr_addr = maddr;
      end else begin
         merr = 1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(bit contig);
      wr_t    w;
      ent_t   e;
      longint pt;
      bit     havep;
      havep = 0;
      pt    = 0;
      repeat (3) @(negedge clk);
      chk("wr_count", wq.size(), exq.size());
      while (wq.size() > 0 && exq.size() > 0) begin
         w = wq.pop_front();
         e = exq.pop_front();
         chk("addr", w.addr, e.addr);
         chk("imm", dec(e.f, w.w), exp_imm(e.f, e.imm));
         chk("fields",
             flds(e.f, w.w[31:25], w.w[24:20], w.w[19:15],
                  w.w[14:12], w.w[11:7], w.w[6:0]),
             flds(e.f, e.f7, e.rs2, e.rs1, e.f3, e.rd, e.opc));
         if (contig && havep) chk("b2b", w.t - pt, 1);
         pt    = w.t;
         havep = 1;
      end
      wq.delete();
      exq.delete();
   endtask

   task automatic end_check();
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("count", count, mcnt);
      chk("err", err, merr);
      if (merr) chk("err_addr", err_addr, merr_addr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ent_t e;
      rst = 1'b1; start = 1'b0; base_addr = '0;
      in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0;
      in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
      in_imm = '0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_erraddr", err_addr, 0);
      chk("rst_count", count, 0);
      chk("rst_ready", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);

      // addi x1,x0,-1 then B -2 halfwords then J +2048
      begin_sess(0);
      send(mk(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF), 0);
      chk("t1_we", imem_we, 1);
      chk("t1_addr", imem_addr, 0);
      chk("t1_data", imem_wdata, 32'hFFF00093);
      chk("t1_count", count, 1);
      send(mk(3, 7'h63, 5'd0, 5'd2, 5'd3, 3'd1, 32'hFFFFFFFE), 0);
      chk("t2_bdec", dec(3, imem_wdata), 32'hFFFFFFFE);
      send(mk(5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'd2048), 1);
      chk("t2_jdec", dec(5, imem_wdata), 32'd2048);
      chk("t1_done_lat", done, 0);
      chk("t1_busy", busy, 1);
      drain(1);
      end_check();

      for (int f = 0; f < 6; f++) begin
         begin_sess(int'($urandom_range(0, 20)));
         for (int i = 0; i < 1000; i++)
            send(rnd(f), i == 999);
         drain(1);
         end_check();
      end

      // U immediate with low bits set, sandwiched between good entries
      begin_sess(5);
      send(rnd(1), 0);
      send(mk(4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'h00001001), 0);
      send(rnd(1), 1);
      drain(0);
      end_check();

      // illegal format code
      begin_sess(40);
      e = rnd(1);
      e.f = 7;
      send(e, 0);
      send(rnd(1), 1);
      drain(0);
      end_check();

      // last writable word, then ready stays low
      begin_sess(DEPTH - 2);
      chk("err_clear", err, 0);
      send(rnd(1), 0);
      send(rnd(2), 0);
      chk("full_ready", in_ready, 0);
      in_valid = 1'b1;
      repeat (5) @(negedge clk);
      chk("full_ready_hold", in_ready, 0);
      in_valid = 1'b0;
      drain(1);
      end_check();

      // reset while a write is in flight
      begin_sess(0);
      send(rnd(1), 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_we", imem_we, 0);
      chk("mid_busy", busy, 0);
      chk("mid_count", count, 0);
      chk("mid_addr", imem_addr, 0);
      chk("mid_wdata", imem_wdata, 0);
      chk("mid_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drain(0);

      // start during RUN must not move the address
      begin_sess(0);
      send(rnd(2), 0);
      start     = 1'b1;
      base_addr = AW'(100);
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy", busy, 1);
      send(rnd(4), 1);
      drain(0);
      end_check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
